// File: rtl/acq_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and the ADC/SCE/DAC blocks it paces.
// The sequencer takes the master view; the datapath blocks (or a bench) take the slave view.
interface acq_frame_sequencer_if #(
    parameter int unsigned N_ADC = 2
);
    logic             run;
    logic             sample_tick;
    logic [N_ADC-1:0] adc_done;
    logic             adc_start;
    logic             sce_start;
    logic             sce_done;
    logic             dac_start;
    logic [3:0]       dac_addr;
    logic             dac_done;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        input  run,
        input  sample_tick,
        input  adc_done,
        input  sce_done,
        input  dac_done,
        output adc_start,
        output sce_start,
        output dac_start,
        output dac_addr,
        output busy,
        output frame_cnt,
        output err,
        output err_code
    );

    modport slave (
        output run,
        output sample_tick,
        output adc_done,
        output sce_done,
        output dac_done,
        input  adc_start,
        input  sce_start,
        input  dac_start,
        input  dac_addr,
        input  busy,
        input  frame_cnt,
        input  err,
        input  err_code
    );
endinterface

// File: rtl/acq_frame_sequencer.sv
// Frame sequencer for the ADC -> SCE -> DAC chain: one frame per sample_tick, per-phase watchdog.
// Optional OVERRUN_DETECT_EN adds overrun/ovr_cnt outputs counting ticks that land mid-frame.
module acq_frame_sequencer #(
    parameter int unsigned N_ADC       = 2,
    parameter int unsigned N_DAC_CH    = 3,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 13
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef OVERRUN_DETECT_EN
    output logic                 overrun,
    output logic [7:0]           ovr_cnt,
`endif
    acq_frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StAdc,
        StSce,
        StDac,
        StErr
    } state_e;

    localparam logic [1:0] ErrAdc = 2'b01;
    localparam logic [1:0] ErrSce = 2'b10;
    localparam logic [1:0] ErrDac = 2'b11;

    state_e           state_q;
    logic             adc_start_q;
    logic             sce_start_q;
    logic             dac_start_q;
    logic [3:0]       dac_addr_q;
    logic             busy_q;
    logic [15:0]      frame_cnt_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [N_ADC-1:0] mask_q;
    logic [TO_W-1:0]  wdog_q;

    logic [N_ADC-1:0] adc_seen;
    logic             adc_all;
    logic             wdog_expired;
    logic             last_ch;

    // A done in the same cycle as the mask update must count, hence the OR with the live inputs.
    assign adc_seen     = mask_q | bus.adc_done;
    assign adc_all      = &adc_seen;
    assign wdog_expired = (wdog_q == TO_W'(TIMEOUT_CYC - 1));
    assign last_ch      = (dac_addr_q == 4'(N_DAC_CH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            adc_start_q <= 1'b0;
            sce_start_q <= 1'b0;
            dac_start_q <= 1'b0;
            dac_addr_q  <= 4'd0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            mask_q      <= '0;
            wdog_q      <= '0;
        end else begin
            adc_start_q <= 1'b0;
            sce_start_q <= 1'b0;
            dac_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    err_q      <= 1'b0;
                    err_code_q <= 2'b00;
                    if (bus.run) begin
                        state_q <= StWaitTick;
                    end
                end
                StWaitTick: begin
                    if (!bus.run) begin
                        state_q <= StIdle;
                    end else if (bus.sample_tick) begin
                        state_q     <= StAdc;
                        adc_start_q <= 1'b1;
                        mask_q      <= '0;
                        wdog_q      <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                StAdc: begin
                    mask_q <= adc_seen;
                    if (adc_all) begin
                        state_q     <= StSce;
                        sce_start_q <= 1'b1;
                        wdog_q      <= '0;
                    end else if (wdog_expired) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_code_q <= ErrAdc;
                        busy_q     <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
                StSce: begin
                    if (bus.sce_done) begin
                        state_q     <= StDac;
                        dac_addr_q  <= 4'd0;
                        dac_start_q <= 1'b1;
                        wdog_q      <= '0;
                    end else if (wdog_expired) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_code_q <= ErrSce;
                        busy_q     <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
                StDac: begin
                    if (bus.dac_done) begin
                        if (!last_ch) begin
                            dac_addr_q  <= dac_addr_q + 4'd1;
                            dac_start_q <= 1'b1;
                            wdog_q      <= '0;
                        end else begin
                            // Frame complete; run is only honoured here so handshakes finish.
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            busy_q      <= 1'b0;
                            state_q     <= bus.run ? StWaitTick : StIdle;
                        end
                    end else if (wdog_expired) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_code_q <= ErrDac;
                        busy_q     <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
                StErr: begin
                    if (!bus.run) begin
                        state_q    <= StIdle;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adc_start = adc_start_q;
    assign bus.sce_start = sce_start_q;
    assign bus.dac_start = dac_start_q;
    assign bus.dac_addr  = dac_addr_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

`ifdef OVERRUN_DETECT_EN
    logic in_frame;
    assign in_frame = (state_q == StAdc) || (state_q == StSce) || (state_q == StDac);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            ovr_cnt <= 8'd0;
        end else begin
            if (state_q == StIdle) begin
                overrun <= 1'b0;
            end else if (in_frame && bus.sample_tick) begin
                overrun <= 1'b1;
            end
            if (in_frame && bus.sample_tick && (ovr_cnt != 8'hFF)) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
        end
    end
`else
    // Ticks outside WAIT_TICK are simply dropped when overrun detection is not built in.
`endif

endmodule
